// File: rtl/sprite_address_gen.sv
// Sprite-memory address generator: runs one sprite line of SPRITE_W pixels, doing a
// rectangle hit test with optional flips, and delivers addresses through a 2-stage pipeline.
module sprite_address_gen #(
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 10,
  parameter int SIZE_ADDRESS = 14,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 20,
  parameter int BG_ADDRESS   = 16383
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  input  logic [SIZE_X-1:0]       pixel_x,
  input  logic [SIZE_Y-1:0]       pixel_y,
  input  logic [31:0]             sprite_datas,
  input  logic                    sprite_on,
  output logic [SIZE_ADDRESS-1:0] memory_address,
  output logic                    address_valid,
  output logic                    counter_finished,
  output logic [1:0]              state_dbg
);

  // Handshake: sprite_on acts as a level request; it must stay high for the whole run,
  // and dropping it at any RUN edge abandons the line without a finish pulse.

  localparam int CW = $clog2(SPRITE_W);
  localparam logic [CW-1:0] LAST = CW'(SPRITE_W - 1);
  localparam logic [31:0] W32  = 32'(SPRITE_W);
  localparam logic [31:0] H32  = 32'(SPRITE_H);
  localparam logic [31:0] AREA = 32'(SPRITE_W * SPRITE_H);
  localparam logic [SIZE_ADDRESS-1:0] BG = SIZE_ADDRESS'(BG_ADDRESS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [30:0]   desc;
  logic          unused_desc_msb;

  logic        s1_valid;
  logic        s1_hit;
  logic [31:0] s1_col;
  logic [31:0] s1_row;
  logic [8:0]  s1_offset;

  logic [31:0] px, py, ox, oy, col_c, row_c, addr_c;
  logic        hit_c;

  assign unused_desc_msb = sprite_datas[31];
  assign state_dbg       = state;

  // 32-bit arithmetic keeps origin + size from wrapping for any realistic field width.
  always_comb begin
    px     = 32'(pixel_x);
    py     = 32'(pixel_y);
    ox     = 32'(desc[28:19]);
    oy     = 32'(desc[18:9]);
    hit_c  = (px >= ox) && (px < ox + W32) && (py >= oy) && (py < oy + H32);
    col_c  = px - ox;
    row_c  = py - oy;
    if (desc[29]) col_c = W32 - 32'd1 - col_c;
    if (desc[30]) row_c = H32 - 32'd1 - row_c;
    addr_c = 32'(s1_offset) * AREA + s1_row * W32 + s1_col;
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state            <= IDLE;
      counter          <= '0;
      desc             <= '0;
      s1_valid         <= 1'b0;
      s1_hit           <= 1'b0;
      s1_col           <= '0;
      s1_row           <= '0;
      s1_offset        <= '0;
      memory_address   <= BG;
      address_valid    <= 1'b0;
      counter_finished <= 1'b0;
    end else begin
      s1_valid         <= 1'b0;
      counter_finished <= 1'b0;

      if (s1_valid && s1_hit) begin
        memory_address <= addr_c[SIZE_ADDRESS-1:0];
        address_valid  <= 1'b1;
      end else begin
        memory_address <= BG;
        address_valid  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sprite_on) begin
            desc    <= sprite_datas[30:0];
            counter <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!sprite_on) begin
            state <= IDLE;
          end else begin
            s1_valid  <= 1'b1;
            s1_hit    <= hit_c;
            s1_col    <= col_c;
            s1_row    <= row_c;
            s1_offset <= desc[8:0];
            counter   <= counter + 1'b1;
            if (counter == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          counter_finished <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          if (sprite_on) begin
            desc    <= sprite_datas[30:0];
            counter <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sprite_address_gen.md
# sprite_address_gen

Parametrised successor to the fixed 20x20 sprite line counter. Generates the sprite-memory address for each pixel in one run across a sprite line. Adds configurable sprite width and height, a full rectangle hit test (X and Y), horizontal and vertical flip, and a 2-stage registered address pipeline with a valid flag. It sits between the sprite scanner, which supplies `sprite_datas` and `sprite_on`, and the sprite ROM address port.

## Interface
- `SIZE_X`, default 10: width of `pixel_x` and of the sprite X field.
- `SIZE_Y`, default 10: width of `pixel_y` and of the sprite Y field.
- `SIZE_ADDRESS`, default 14: memory address width.
- `SPRITE_W`, default 20: sprite width in pixels; must be at least 2.
- `SPRITE_H`, default 20: sprite height in lines; must be at least 1.
- `BG_ADDRESS`, default 16383: address output whenever no sprite pixel is addressed.
- `clk_pixel` input 1: pixel clock. All flops update on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `pixel_x` input SIZE_X: current screen column.
- `pixel_y` input SIZE_Y: current screen line.
- `sprite_datas` input 32: sprite descriptor, fields as follows.
  - [8:0] sprite offset (index).
  - [18:9] Y origin.
  - [28:19] X origin.
  - [29] hflip.
  - [30] vflip.
  - [31] ignored.
- `sprite_on` input 1: request to run one line of the sprite.
- `memory_address` output SIZE_ADDRESS: registered sprite address, or `BG_ADDRESS` when none.
- `address_valid` output 1: `memory_address` is a sprite pixel inside the sprite rectangle.
- `counter_finished` output 1: one-cycle pulse marking the last output of a completed run.

## Operation
- **Reset.** While `reset_n` is 0 at an edge:
  - state goes to IDLE and the counter to 0;
  - both pipeline stages are cleared;
  - `memory_address` = `BG_ADDRESS`, `address_valid` = 0, `counter_finished` = 0.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE.** If `sprite_on` = 1: latch `sprite_datas`, clear the counter, go to RUN. Otherwise stay in IDLE.
- **RUN.** Lasts exactly `SPRITE_W` cycles.
  - Each cycle, stage 1 samples `pixel_x`/`pixel_y` and the counter increments.
  - When counter = `SPRITE_W`-1, go to DRAIN.
  - If `sprite_on` = 0 at any RUN edge, abort to IDLE:
    - stage 1 is invalidated at that edge;
    - no `counter_finished` pulse is produced;
    - an output already in stage 2 still drains.
- **DRAIN.** One cycle; stage 2 takes the last stage-1 result. Go to DONE.
- **DONE.** One cycle.
  - If `sprite_on` = 1: re-latch `sprite_datas` and go to RUN.
  - Otherwise go to IDLE.
- **Stage 1 arithmetic.** All comparisons are zero-extended, with one extra bit so `origin + size` never wraps.
  - hit = (x ≤ `pixel_x` < x+`SPRITE_W`) AND (y ≤ `pixel_y` < y+`SPRITE_H`).
  - col = `pixel_x` − x; row = `pixel_y` − y.
  - hflip: col' = `SPRITE_W`−1−col. vflip: row' = `SPRITE_H`−1−row.
- **Stage 2 address.**
  - addr = offset·(`SPRITE_W`·`SPRITE_H`) + row'·`SPRITE_W` + col', truncated modulo 2^`SIZE_ADDRESS`.
  - If hit and the sample came from RUN: `memory_address` = addr, `address_valid` = 1.
  - Otherwise: `memory_address` = `BG_ADDRESS`, `address_valid` = 0.
- **Descriptor latching.** Changes on `sprite_datas` during RUN have no effect; only the latched copy is used.

## Timing
- **Edge numbering.** E0 is the edge where IDLE (or DONE) sees `sprite_on` = 1.
- **Pixel sampling.** Pixels are sampled at E1..E_W.
- **Latency.** 2 edges: the pixel sampled at E_k appears on `memory_address` after E_(k+1).
  - First output: after E2. Last output: after E_(W+1).
- **Finish pulse.** `counter_finished` = 1 only in the cycle after E_(W+1), coincident with the W-th output (DONE state). It is 0 in every other cycle.
- **Back-to-back runs.** With `sprite_on` held at 1, the next RUN begins sampling at E_(W+3). Period is `SPRITE_W`+2 cycles.
- **After an abort.** BG/valid=0 appears no later than 2 edges after the abort edge.
- **Reset during any state.** Outputs are at reset values after the reset edge, with no partial pulse.

## Test plan
- **Basic line.** Defaults; descriptor offset=2, x=100, y=50, no flip; `pixel_y`=53; `pixel_x` = 100..119 on E1..E20.
  - → addresses 860..879 after E2..E21, valid=1.
  - → `counter_finished` = 1 only with 879.
- **hflip.** Same stimulus with hflip=1 → 879 down to 860. With vflip=1 instead → 1120..1139.
- **Miss.**
  - `pixel_y`=70 (≥ y+20) → all 20 outputs are 16383 with valid=0, and `counter_finished` still pulses once.
  - `pixel_x`=99 → 16383 for that sample.
- **Abort.** Drop `sprite_on` at E10 → no finish pulse; `memory_address`=16383 by E12; state is IDLE.
- **Reset mid-run.** `reset_n`=0 at E5 → after E5: 16383, valid=0, finished=0. Restart on `sprite_on` then reproduces the basic-line result.
- **Truncation.** offset=511, x=0, y=0, hit at (0,0) → address 7792 (204400 mod 16384).
